// File: rtl/pfp_pkg.sv
// Shared types for the front-panel controller: halt FSM encoding, CTRL
// command bits, fixed register offsets and the status word layout.
package pfp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALTING = 3'd1,
    ST_HALTED  = 3'd2,
    ST_STEP    = 3'd3
  } halt_state_e;

  typedef enum logic [1:0] {
    PEND_NONE   = 2'd0,
    PEND_RESUME = 2'd1,
    PEND_STEP   = 2'd2
  } pend_e;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_HALT   = 2'd1,
    CMD_RESUME = 2'd2,
    CMD_STEP   = 2'd3
  } cmd_e;

  localparam int CTRL_HALT_BIT   = 0;
  localparam int CTRL_RESUME_BIT = 1;
  localparam int CTRL_STEP_BIT   = 2;

  localparam logic [2:0] OFS_SW   = 3'd6;
  localparam logic [2:0] OFS_CTRL = 3'd7;

  // Status word: err_cnt in the top byte, pend and state in the low bits.
  typedef struct packed {
    logic [7:0]  err_cnt;
    logic [2:0]  rsvd;
    pend_e       pend;
    halt_state_e state;
  } status_t;

  function automatic cmd_e decode_ctrl(input logic [2:0] bits);
    if (bits[CTRL_HALT_BIT])   return CMD_HALT;
    if (bits[CTRL_RESUME_BIT]) return CMD_RESUME;
    if (bits[CTRL_STEP_BIT])   return CMD_STEP;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/pfp_if.sv
// I/O bus seen by the front-panel controller: address, data and strobes.
interface pfp_if;
  logic [15:0] ec_ab;
  logic [15:0] ec_db_in;
  logic [15:0] ec_db_out;
  logic        ec_db_oe;
  logic        ec_nsysdev;
  logic        ec_nr;
  logic        ec_nw;

  modport master (
    output ec_ab, ec_db_in, ec_nsysdev, ec_nr, ec_nw,
    input  ec_db_out, ec_db_oe
  );

  modport slave (
    input  ec_ab, ec_db_in, ec_nsysdev, ec_nr, ec_nw,
    output ec_db_out, ec_db_oe
  );
endinterface

// File: rtl/pfp_halt_fsm.sv
// Halt sequencer: holds HALT# for a minimum time, then services resume/step.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | running, HALT# released
//   ST_HALTING | HALT# held, hold counter running down to zero
//   ST_HALTED  | HALT# held, waiting for resume or step
//   ST_STEP    | HALT# released for exactly one clock, then back to HALTED
module pfp_halt_fsm
  import pfp_pkg::*;
#(
  parameter int HALT_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  input  cmd_e        cmd_i,
  output halt_state_e state_o,
  output pend_e       pend_o,
  output logic        nhalt_oe_o
);

  localparam logic [7:0] HOLD_LOAD = 8'(HALT_HOLD - 1);

  halt_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  pend_e       pend_q, pend_d;
  pend_e       act_q, act_d;
  logic        go_halt, go_resume, go_step;

  assign go_halt   = cmd_valid_i && (cmd_i == CMD_HALT);
  assign go_resume = cmd_valid_i && (cmd_i == CMD_RESUME);
  assign go_step   = cmd_valid_i && (cmd_i == CMD_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= PEND_NONE;
      act_q   <= PEND_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    act_d   = PEND_NONE;
    case (state_q)
      ST_IDLE: begin
        if (go_halt) begin
          state_d = ST_HALTING;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HALTING: begin
        if (go_resume)    pend_d = PEND_RESUME;
        else if (go_step) pend_d = PEND_STEP;
        if (cnt_q == 8'd0) begin
          // The pending command moves into act_q so HALTED sees it once.
          state_d = ST_HALTED;
          act_d   = pend_d;
          pend_d  = PEND_NONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HALTED: begin
        if (go_resume || act_q == PEND_RESUME)  state_d = ST_IDLE;
        else if (go_step || act_q == PEND_STEP) state_d = ST_STEP;
      end
      ST_STEP:  state_d = ST_HALTED;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign state_o    = state_q;
  assign pend_o     = pend_q;
  assign nhalt_oe_o = (state_q == ST_HALTING) || (state_q == ST_HALTED);

endmodule

// File: rtl/pfp_ctrl.sv
// Front-panel I/O block: address decode, write-strobe edge detect, light
// registers, error counter and combinational read mux around the halt FSM.
module pfp_ctrl
  import pfp_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'h0030,
  parameter int          NLIGHTS   = 4,
  parameter int          HALT_HOLD = 16
) (
  input  logic                   ec_clk4,
  input  logic                   ec_reset,
  pfp_if.slave                   bus,
  output logic                   ec_nhalt_oe,
  input  logic [15:0]            sw,
  output logic [16*NLIGHTS-1:0]  lights,
  output logic                   halted
);

  logic                  hit;
  logic [2:0]            ofs;
  logic                  wr_ev;
  logic                  nw_q;
  logic                  blk_q;
  logic [16*NLIGHTS-1:0] lights_q, lights_d;
  logic [7:0]            err_q, err_d;
  logic                  cmd_valid;
  cmd_e                  cmd;
  halt_state_e           state;
  pend_e                 pend;
  status_t               status;
  logic [15:0]           rd_data;

  assign hit = ((bus.ec_ab & 16'hfff8) == BASE) && !bus.ec_nsysdev;
  assign ofs = bus.ec_ab[2:0];

  // blk_q masks a strobe that was already low during reset until it rises.
  assign wr_ev = hit && !bus.ec_nw && nw_q && !blk_q;

  always_ff @(posedge ec_clk4) begin
    if (ec_reset) begin
      nw_q     <= 1'b1;
      blk_q    <= ~bus.ec_nw;
      lights_q <= '0;
      err_q    <= 8'd0;
    end else begin
      nw_q     <= bus.ec_nw;
      blk_q    <= blk_q & ~bus.ec_nw;
      lights_q <= lights_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    lights_d = lights_q;
    err_d    = err_q;
    for (int k = 0; k < NLIGHTS; k++) begin
      if (wr_ev && ofs == 3'(k)) lights_d[16*k +: 16] = bus.ec_db_in;
    end
    if (wr_ev && int'(ofs) >= NLIGHTS && ofs != OFS_CTRL && err_q != 8'hff) begin
      err_d = err_q + 8'd1;
    end
  end

  assign cmd_valid = wr_ev && (ofs == OFS_CTRL);
  assign cmd       = decode_ctrl(bus.ec_db_in[2:0]);

  pfp_halt_fsm #(
    .HALT_HOLD (HALT_HOLD)
  ) u_halt_fsm (
    .clk         (ec_clk4),
    .rst         (ec_reset),
    .cmd_valid_i (cmd_valid),
    .cmd_i       (cmd),
    .state_o     (state),
    .pend_o      (pend),
    .nhalt_oe_o  (ec_nhalt_oe)
  );

  always_comb begin
    status.err_cnt = err_q;
    status.rsvd    = 3'b000;
    status.pend    = pend;
    status.state   = state;
  end

  always_comb begin
    rd_data = 16'h0000;
    for (int k = 0; k < NLIGHTS; k++) begin
      if (ofs == 3'(k)) rd_data = lights_q[16*k +: 16];
    end
    if (ofs == OFS_SW)   rd_data = sw;
    if (ofs == OFS_CTRL) rd_data = status;
  end

  assign bus.ec_db_out = rd_data;
  assign bus.ec_db_oe  = hit && !bus.ec_nr && bus.ec_nw;
  assign lights        = lights_q;
  assign halted        = (state == ST_HALTED);

endmodule

// File: tb/tb_pfp_ctrl.sv
// Self-checking bench for pfp_ctrl: reads go through a scoreboard queue that
// a negedge monitor drains whenever the DUT drives the bus.
module tb_pfp_ctrl;

  localparam int NL = 4;
  localparam int HH = 16;

  logic           ec_clk4 = 1'b0;
  logic           ec_reset;
  logic           ec_nhalt_oe;
  logic [15:0]    sw;
  logic [16*NL-1:0] lights;
  logic           halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] addr_q[$];

  int hold_cur = 0, hold_run = 0;
  int halt_cur = 0, halt_run = 0;

  pfp_if bus();

  pfp_ctrl #(
    .BASE      (16'h0030),
    .NLIGHTS   (NL),
    .HALT_HOLD (HH)
  ) dut (
    .ec_clk4     (ec_clk4),
    .ec_reset    (ec_reset),
    .bus         (bus),
    .ec_nhalt_oe (ec_nhalt_oe),
    .sw          (sw),
    .lights      (lights),
    .halted      (halted)
  );

  always #5 ec_clk4 = ~ec_clk4;

  // Scoreboard monitor: every bus drive must match the oldest expected read.
  always @(negedge ec_clk4) begin
    if (bus.ec_db_oe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read addr=%h got=%h expected no drive", bus.ec_ab, bus.ec_db_out);
      end else begin
        logic [15:0] e, a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (bus.ec_db_out !== e) begin
          errors++;
          $display("FAIL read_%h got=%h expected=%h", a, bus.ec_db_out, e);
        end
      end
    end
  end

  // Run-length trackers for HALT# and halted.
  always @(negedge ec_clk4) begin
    if (ec_nhalt_oe) hold_cur++;
    else begin
      if (hold_cur != 0) hold_run = hold_cur;
      hold_cur = 0;
    end
    if (halted) halt_cur++;
    else begin
      if (halt_cur != 0) halt_run = halt_cur;
      halt_cur = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(posedge ec_clk4); #1;
    bus.ec_ab = a; bus.ec_db_in = d; bus.ec_nw = 1'b0;
    @(posedge ec_clk4); #1;
    bus.ec_nw = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] e);
    @(posedge ec_clk4); #1;
    bus.ec_ab = a; bus.ec_nr = 1'b0;
    exp_q.push_back(e);
    addr_q.push_back(a);
    @(negedge ec_clk4);
    @(posedge ec_clk4); #1;
    bus.ec_nr = 1'b1;
  endtask

  initial begin
    int cnt;
    bit done;

    ec_reset = 1'b1;
    bus.ec_ab = 16'h0000; bus.ec_db_in = 16'h0000;
    bus.ec_nsysdev = 1'b0; bus.ec_nr = 1'b1; bus.ec_nw = 1'b1;
    sw = 16'hBEEF;
    repeat (3) @(posedge ec_clk4);
    #1 ec_reset = 1'b0;

    // Reset state
    @(negedge ec_clk4);
    check("rst_lights", 64'(lights), 64'h0);
    check("rst_nhalt_oe", 64'(ec_nhalt_oe), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    bus_read(16'h0037, 16'h0000);

    // Light registers and read mux
    bus_write(16'h0031, 16'hA5A5);
    @(negedge ec_clk4);
    check("light1_after_write", 64'(lights[31:16]), 64'hA5A5);
    bus_read(16'h0031, 16'hA5A5);
    bus_write(16'h0030, 16'h1234);
    bus_write(16'h0033, 16'hFFFF);
    bus_read(16'h0030, 16'h1234);
    bus_read(16'h0033, 16'hFFFF);
    bus_read(16'h0032, 16'h0000);
    bus_read(16'h0036, 16'hBEEF);
    bus_read(16'h0034, 16'h0000);
    bus_write(16'h0038, 16'h5A5A);
    bus.ec_nsysdev = 1'b1;
    bus_write(16'h0031, 16'hDEAD);
    @(posedge ec_clk4); #1;
    bus.ec_ab = 16'h0031; bus.ec_nr = 1'b0;
    @(negedge ec_clk4);
    check("oe_nsysdev_high", 64'(bus.ec_db_oe), 64'h0);
    @(posedge ec_clk4); #1;
    bus.ec_nr = 1'b1; bus.ec_nsysdev = 1'b0;
    @(negedge ec_clk4);
    check("lights_after_misses", 64'(lights), 64'hFFFF_0000_A5A5_1234);

    // Halt: HALT# held for HALT_HOLD cycles, then HALTED
    bus_write(16'h0037, 16'h0001);
    cnt = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge ec_clk4);
      if (halted) done = 1;
      else if (ec_nhalt_oe) cnt++;
    end
    check("halt_reached", 64'(done), 64'h1);
    check("halting_cycles", 64'(cnt), 64'(HH));
    check("halted_nhalt_oe", 64'(ec_nhalt_oe), 64'h1);
    bus_read(16'h0037, 16'h0002);

    // HALT has priority in CTRL=7 and is ignored while halted
    bus_write(16'h0037, 16'h0007);
    repeat (3) @(negedge ec_clk4);
    check("ctrl7_stays_halted", 64'({halted, ec_nhalt_oe}), 64'h3);

    // Step releases HALT# for one clock
    bus_write(16'h0037, 16'h0004);
    @(negedge ec_clk4);
    check("step_release", 64'({halted, ec_nhalt_oe}), 64'h0);
    @(negedge ec_clk4);
    check("step_back_halted", 64'({halted, ec_nhalt_oe}), 64'h3);

    // RESUME beats STEP in CTRL=6
    bus_write(16'h0037, 16'h0006);
    @(negedge ec_clk4);
    check("resume_idle", 64'({halted, ec_nhalt_oe}), 64'h0);
    @(negedge ec_clk4);
    check("resume_stays_idle", 64'({halted, ec_nhalt_oe}), 64'h0);

    // Resume queued during HALTING
    hold_run = 0; halt_run = 0;
    bus_write(16'h0037, 16'h0001);
    @(posedge ec_clk4);
    bus_write(16'h0037, 16'h0002);
    bus_read(16'h0037, 16'h0009);
    repeat (30) @(negedge ec_clk4);
    check("pend_resume_hold_run", 64'(hold_run), 64'(HH + 1));
    check("pend_resume_halted_run", 64'(halt_run), 64'h1);
    check("pend_resume_idle", 64'({halted, ec_nhalt_oe}), 64'h0);

    // Later command wins: resume then step leaves a step pending
    hold_run = 0; halt_run = 0;
    bus_write(16'h0037, 16'h0001);
    bus_write(16'h0037, 16'h0002);
    bus_write(16'h0037, 16'h0004);
    bus_read(16'h0037, 16'h0011);
    repeat (30) @(negedge ec_clk4);
    check("pend_step_hold_run", 64'(hold_run), 64'(HH + 1));
    check("pend_step_halted_run", 64'(halt_run), 64'h1);
    check("pend_step_halted", 64'({halted, ec_nhalt_oe}), 64'h3);
    bus_write(16'h0037, 16'h0002);
    @(negedge ec_clk4);
    check("pend_step_resumed", 64'(halted), 64'h0);

    // Error counter: a long strobe counts once, then saturation
    @(posedge ec_clk4); #1;
    bus.ec_ab = 16'h0034; bus.ec_db_in = 16'h1111; bus.ec_nw = 1'b0;
    repeat (20) @(posedge ec_clk4);
    #1 bus.ec_nw = 1'b1;
    bus_read(16'h0037, 16'h0100);
    bus_write(16'h0036, 16'h9999);
    bus_read(16'h0037, 16'h0200);
    bus_read(16'h0036, 16'hBEEF);
    for (int i = 0; i < 300; i++) bus_write(16'h0035, 16'(i));
    bus_read(16'h0037, 16'hFF00);
    check("lights_after_errs", 64'(lights), 64'hFFFF_0000_A5A5_1234);

    // Reset during HALTING with the write strobe held low
    bus_write(16'h0037, 16'h0001);
    repeat (5) @(negedge ec_clk4);
    check("pre_reset_holding", 64'(ec_nhalt_oe), 64'h1);
    @(posedge ec_clk4); #1;
    ec_reset = 1'b1;
    bus.ec_ab = 16'h0030; bus.ec_db_in = 16'h5555; bus.ec_nw = 1'b0;
    @(posedge ec_clk4); #1;
    ec_reset = 1'b0;
    @(negedge ec_clk4);
    check("reset_release", 64'({halted, ec_nhalt_oe}), 64'h0);
    check("reset_lights", 64'(lights), 64'h0);
    repeat (3) @(negedge ec_clk4);
    check("held_strobe_no_write", 64'(lights), 64'h0);
    @(posedge ec_clk4); #1;
    bus.ec_nw = 1'b1;
    bus_read(16'h0037, 16'h0000);
    bus_write(16'h0030, 16'h7777);
    @(negedge ec_clk4);
    check("write_after_reset", 64'(lights), 64'h7777);

    repeat (2) @(negedge ec_clk4);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
